cache_trace_driver: RTL
=======================

# cache_trace_driver

Synthesizable trace player and checker for the cache memory hierarchy. It is the parametrised successor of the cache benchmark bench and is usable in simulation and on FPGA. It replays a trace of CPU accesses into `top_memory_hierarchy` through the `cpu_to_cache` / `cache_to_cpu` interface, and checks every read return in order against the expected data carried in the trace. It also accumulates access, miss and stall-cycle statistics.

## Interface
- `TRACE_DEPTH`, 1024: number of trace entries addressable; `TRACE_AW = $clog2(TRACE_DEPTH)`.
- `CNT_W`, 32: width of every statistic counter.
- `EXP_DEPTH`, 8: depth of the expected-read-data FIFO (power of two, ≥2).
- `clk  in  1`: single clock; all state updates on rising edge.
- `rst  in  1`: synchronous, active-high reset.
- `start  in  1`: one-cycle pulse; launches a run from IDLE or DONE.
- `num_access  in  TRACE_AW+1`: number of trace entries to replay; sampled on `start`.
- `trace_addr  out  TRACE_AW`: trace memory index (asynchronous-read memory).
- `trace_data  in  65`: trace word. Bit [64] is rw (1 = write). Bits [51:32] are addr. Bits [31:0] are write data, or expected data for a read.
- `cpu_to_cache  out  cpu_to_cache_type`: request to the cache (valid, rw, addr, data).
- `cache_to_cpu  in  cache_to_cpu_type`: cache response (ready, stopped, data).
- `busy`, `done`  out  1: run in progress / run finished (done held until next `start` or `rst`).
- `error  out  1`: sticky; set on any mismatch or underflow.
- `err_count  out  CNT_W`: mismatches + underflows.
- `reads`, `writes`, `read_misses`, `write_misses`, `read_stalls`, `write_stalls`  out  CNT_W each: statistics.

## Operation
- FSM states: IDLE → RUN → DRAIN → DONE.
  - IDLE/DONE + `start`: clear all counters and `error`, and set idx = 0. Go to RUN, or straight to DONE if `num_access` = 0.
  - RUN: `cpu_to_cache.valid` = 1 with rw/addr/data taken combinationally from `trace_data` at `trace_addr` = idx.
    - Exception: valid = 0 while the expected FIFO is full and the current entry is a read.
  - Accept = valid & !stopped at a rising edge.
    - On accept, idx += 1 and `reads` or `writes` += 1.
    - On a read accept, push trace bits [31:0] into the expected FIFO.
    - Record the accepted rw in `pend_rw`.
  - RUN → DRAIN on the accept of entry `num_access`-1. In DRAIN valid = 0.
  - DRAIN → DONE when the FIFO is empty and `cache_to_cpu.ready` = 0.
- Check: at each edge with `ready` = 1, pop the FIFO and compare with `cache_to_cpu.data`. A mismatch increments `err_count` and sets `error`.
  - Underflow (`ready` with FIFO empty before that edge's push) also counts as an error. No pop occurs.
  - Push and pop in the same edge are legal.
- Miss: the rising edge of `stopped` (stopped & !stopped_q) increments `read_misses` when `pend_rw` = 0, otherwise `write_misses`.
- Stall: every cycle with `stopped` = 1 increments `read_stalls` or `write_stalls` according to `pend_rw`. Counting is active in RUN and DRAIN only.
- Counters saturate at all-ones; no wrap.
- `start` while in RUN/DRAIN is ignored.
- `rst` at any time: all state returns to reset values, and any in-flight cache transaction is abandoned.

## Timing
- Reset values: state IDLE, idx 0, `trace_addr` 0, `cpu_to_cache` all zero (valid 0), `busy` 0, `done` 0, `error` 0, all counters 0, FIFO empty, `stopped_q` 0, `pend_rw` 0.
- `start` at edge N: `busy` = 1 and valid = 1 from cycle N+1.
- Back-to-back hits: one accept per cycle, with no bubble.
- `done` rises one cycle after the last read return is checked.
- `busy` = 1 in RUN and DRAIN.
- Statistic outputs are registered and reflect events up to the previous edge.

## Configuration
- `CACHE_TRACE_FIRST_ERR_EN` defined: adds outputs `first_err_idx` (TRACE_AW) and `first_err_exp` / `first_err_got` (32 each).
  - These capture the trace index of the failing read together with the expected and returned data for the first error only.
  - For an underflow, `first_err_exp` = 0.
  - Cleared by `rst` and `start`.
  - Requires a parallel index FIFO.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

## Structure
- Add to the `cache_definition` package:
  - `TRACE_W = 65`;
  - `trace_entry_t` packed struct (rw, pad[11:0], addr[19:0], data[31:0]);
  - `trace_state_t` enum (IDLE, RUN, DRAIN, DONE).
- One sub-module, `expect_fifo`: synchronous FIFO parametrised by width and depth. Outputs full/empty with simultaneous push/pop; same clk/rst.

## Test plan
- Reset mid-RUN (after 3 accepts): next cycle valid = 0, all counters 0, state IDLE; a new `start` replays from idx 0.
- Trace of 4 writes then 4 reads to addr 0x00010–0x0001C, matching data, cache stalls 5 cycles on the first access only: reads = 4, writes = 4, write_misses = 1, write_stalls = 5, err_count = 0, `done` = 1.
- Read where the cache returns 0xDEADBEEF but the trace expects 0x12345678: `error` = 1, err_count = 1. With the macro defined, first_err_exp = 0x12345678 and first_err_got = 0xDEADBEEF.
- EXP_DEPTH = 2 with the cache withholding `ready` for 6 cycles: valid drops after 2 outstanding reads, with no loss, no error and no FIFO overflow.
- `num_access` = 0: `done` = 1 one cycle after `start`, and valid never asserts.
- CNT_W = 4 with 20 writes: writes saturates at 15.

Source files
------------

// File: rtl/cache_definition_pkg.sv
// Cache interface types shared by the hierarchy, plus the trace-driver entry layout and FSM states.
package cache_definition;

  typedef struct packed {
    logic        valid;
    logic        rw;
    logic [31:0] addr;
    logic [31:0] data;
  } cpu_to_cache_type;

  typedef struct packed {
    logic        ready;
    logic        stopped;
    logic [31:0] data;
  } cache_to_cpu_type;

  localparam int TRACE_W = 65;

  typedef struct packed {
    logic        rw;
    logic [11:0] pad;
    logic [19:0] addr;
    logic [31:0] data;
  } trace_entry_t;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} trace_state_t;

endpackage

// File: rtl/cache_trace_driver_expect_fifo.sv
// Synchronous first-word-fall-through FIFO holding expected read data in issue order.
module expect_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_push,
  input  logic [W-1:0] i_din,
  input  logic         i_pop,
  output logic [W-1:0] o_dout,
  output logic         o_full,
  output logic         o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_cnt;
  logic          w_push;
  logic          w_pop;

  assign o_empty = (r_cnt == '0);
  assign o_full  = (r_cnt == (AW+1)'(DEPTH));
  assign o_dout  = r_mem[r_rd];
  assign w_pop   = i_pop && !o_empty;
  // A push into a full FIFO is only legal when a pop frees the slot on the same edge.
  assign w_push  = i_push && (!o_full || w_pop);

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr] <= i_din;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_wr <= r_wr + 1'b1;
      end
      if (w_pop) begin
        r_rd <= r_rd + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_cnt <= r_cnt + 1'b1;
      end else if (w_pop && !w_push) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/cache_trace_driver.sv
// Trace player/checker for the cache hierarchy: replays trace entries, checks read returns in order, keeps stats.
// Optional first-error capture ports are enabled with CACHE_TRACE_FIRST_ERR_EN.
module cache_trace_driver
  import cache_definition::*;
#(
  parameter int  TRACE_DEPTH = 1024,
  parameter int  CNT_W       = 32,
  parameter int  EXP_DEPTH   = 8,
  localparam int TRACE_AW    = $clog2(TRACE_DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [TRACE_AW:0]   num_access,
  output logic [TRACE_AW-1:0] trace_addr,
  input  logic [TRACE_W-1:0]  trace_data,
  output cpu_to_cache_type    cpu_to_cache,
  input  cache_to_cpu_type    cache_to_cpu,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [CNT_W-1:0]    err_count,
  output logic [CNT_W-1:0]    reads,
  output logic [CNT_W-1:0]    writes,
  output logic [CNT_W-1:0]    read_misses,
  output logic [CNT_W-1:0]    write_misses,
  output logic [CNT_W-1:0]    read_stalls,
  output logic [CNT_W-1:0]    write_stalls
`ifdef CACHE_TRACE_FIRST_ERR_EN
  ,
  output logic [TRACE_AW-1:0] first_err_idx,
  output logic [31:0]         first_err_exp,
  output logic [31:0]         first_err_got
`endif
);

`ifdef CACHE_TRACE_FIRST_ERR_EN
  localparam int FW = 32 + TRACE_AW;
`else
  localparam int FW = 32;
`endif

  trace_entry_t        w_entry;
  trace_state_t        r_state;
  logic [TRACE_AW-1:0] r_idx;
  logic [TRACE_AW:0]   r_num;
  logic                r_busy, r_done, r_error, r_stopped_q, r_pend_rw;
  logic [CNT_W-1:0]    r_err_count, r_reads, r_writes;
  logic [CNT_W-1:0]    r_rd_miss, r_wr_miss, r_rd_stall, r_wr_stall;
  logic                w_active, w_valid, w_accept, w_last, w_push, w_pop;
  logic                w_full, w_empty, w_miss, w_underflow, w_mismatch, w_err;
  logic [FW-1:0]       w_fifo_din, w_fifo_dout;
  logic [31:0]         w_exp;
  logic                w_unused_pad;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign w_entry      = trace_entry_t'(trace_data);
  assign w_unused_pad = ^w_entry.pad;
  assign w_active     = (r_state == RUN) || (r_state == DRAIN);
  // Hold off a read when its expected data would have nowhere to go.
  assign w_valid      = (r_state == RUN) && !(w_full && !w_entry.rw);
  assign w_accept     = w_valid && !cache_to_cpu.stopped;
  assign w_last       = (({1'b0, r_idx} + 1'b1) == r_num);
  assign w_push       = w_accept && !w_entry.rw;
  assign w_pop        = w_active && cache_to_cpu.ready && !w_empty;
  assign w_underflow  = w_active && cache_to_cpu.ready && w_empty;
  assign w_exp        = w_fifo_dout[31:0];
  assign w_mismatch   = w_pop && (w_exp != cache_to_cpu.data);
  assign w_err        = w_underflow || w_mismatch;
  assign w_miss       = w_active && cache_to_cpu.stopped && !r_stopped_q;

`ifdef CACHE_TRACE_FIRST_ERR_EN
  assign w_fifo_din = {r_idx, w_entry.data};
`else
  assign w_fifo_din = w_entry.data;
`endif

  expect_fifo #(
    .W     (FW),
    .DEPTH (EXP_DEPTH)
  ) u_expect_fifo (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_push  (w_push),
    .i_din   (w_fifo_din),
    .i_pop   (w_pop),
    .o_dout  (w_fifo_dout),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_comb begin
    cpu_to_cache = '0;
    if (r_state == RUN) begin
      cpu_to_cache.valid = w_valid;
      cpu_to_cache.rw    = w_entry.rw;
      cpu_to_cache.addr  = {12'h000, w_entry.addr};
      cpu_to_cache.data  = w_entry.data;
    end
  end

`ifdef CACHE_TRACE_FIRST_ERR_EN
  logic [TRACE_AW-1:0] r_fe_idx;
  logic [31:0]         r_fe_exp, r_fe_got;

  assign first_err_idx = r_fe_idx;
  assign first_err_exp = r_fe_exp;
  assign first_err_got = r_fe_got;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fe_idx <= '0;
      r_fe_exp <= '0;
      r_fe_got <= '0;
    end else if ((r_state == IDLE || r_state == DONE) && start) begin
      r_fe_idx <= '0;
      r_fe_exp <= '0;
      r_fe_got <= '0;
    end else if (w_err && !r_error) begin
      r_fe_idx <= w_underflow ? r_idx : w_fifo_dout[FW-1:32];
      r_fe_exp <= w_underflow ? 32'h0 : w_exp;
      r_fe_got <= cache_to_cpu.data;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_num       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_stopped_q <= 1'b0;
      r_pend_rw   <= 1'b0;
      r_err_count <= '0;
      r_reads     <= '0;
      r_writes    <= '0;
      r_rd_miss   <= '0;
      r_wr_miss   <= '0;
      r_rd_stall  <= '0;
      r_wr_stall  <= '0;
    end else begin
      r_stopped_q <= cache_to_cpu.stopped;
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_idx       <= '0;
            r_num       <= num_access;
            r_error     <= 1'b0;
            r_err_count <= '0;
            r_reads     <= '0;
            r_writes    <= '0;
            r_rd_miss   <= '0;
            r_wr_miss   <= '0;
            r_rd_stall  <= '0;
            r_wr_stall  <= '0;
            if (num_access == '0) begin
              r_state <= DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= RUN;
              r_busy  <= 1'b1;
              r_done  <= 1'b0;
            end
          end
        end
        RUN: begin
          if (w_accept) begin
            r_idx     <= r_idx + 1'b1;
            r_pend_rw <= w_entry.rw;
            if (w_entry.rw) begin
              r_writes <= sat_inc(r_writes);
            end else begin
              r_reads <= sat_inc(r_reads);
            end
            if (w_last) begin
              r_state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (w_empty && !cache_to_cpu.ready) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase

      // Miss/stall attribution uses the rw of the last accepted request, which the cache is servicing.
      if (w_miss) begin
        if (r_pend_rw) begin
          r_wr_miss <= sat_inc(r_wr_miss);
        end else begin
          r_rd_miss <= sat_inc(r_rd_miss);
        end
      end
      if (w_active && cache_to_cpu.stopped) begin
        if (r_pend_rw) begin
          r_wr_stall <= sat_inc(r_wr_stall);
        end else begin
          r_rd_stall <= sat_inc(r_rd_stall);
        end
      end
      if (w_err) begin
        r_error     <= 1'b1;
        r_err_count <= sat_inc(r_err_count);
      end
    end
  end

  assign trace_addr   = r_idx;
  assign busy         = r_busy;
  assign done         = r_done;
  assign error        = r_error;
  assign err_count    = r_err_count;
  assign reads        = r_reads;
  assign writes       = r_writes;
  assign read_misses  = r_rd_miss;
  assign write_misses = r_wr_miss;
  assign read_stalls  = r_rd_stall;
  assign write_stalls = r_wr_stall;

endmodule
